arith_issue_queue: RTL and testbench

ARITH_ISSUE_QUEUE -- requirements
Module: arith_issue_queue

---
 rtl/arith_issue_queue_pkg.sv | 33 +++
 rtl/arith_rs_entry_wakeup.sv | 29 ++
 rtl/arith_issue_queue.sv | 209 ++++++++++++++++++++
 tb/tb_arith_issue_queue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_issue_queue_pkg.sv
// Shared definitions for the arithmetic issue queue: field widths and the
// reservation-station entry record.
package arith_issue_queue_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 8;

    // One source operand: producer tag, present flag, captured value.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              rdy;
        logic [DATA_W-1:0] val;
    } operand_t;

    // One reservation-station entry.
    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  rob;
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  flag_reg;
        operand_t          a;
        operand_t          b;
        operand_t          f;
    } rs_entry_t;

    // Entry holds an instruction whose three operands are all present.
    function automatic logic entry_issuable(input rs_entry_t e);
        return e.valid && e.a.rdy && e.b.rdy && e.f.rdy;
    endfunction

endpackage

// File: rtl/arith_rs_entry_wakeup.sv
// Operand wakeup for one operand of one entry: when the operand is still
// waiting and a broadcast carries its tag, the broadcast value is captured
// and the operand becomes present.
// Ports:
//   entry_valid      entry holds an instruction
//   opnd             stored operand (tag/rdy/val)
//   bc_valid/bc_reg/bc_val  broadcast bus
//   opnd_c           operand after this cycle's wakeup (combinational)
module arith_rs_entry_wakeup
    import arith_issue_queue_pkg::*;
(
    input  logic              entry_valid,
    input  operand_t          opnd,
    input  logic              bc_valid,
    input  logic [TAG_W-1:0]  bc_reg,
    input  logic [DATA_W-1:0] bc_val,
    output operand_t          opnd_c
);

    // Full-width tag compare; tag 0 is an ordinary tag.
    always_comb begin
        opnd_c = opnd;
        if (entry_valid && !opnd.rdy && bc_valid && (opnd.tag == bc_reg)) begin
            opnd_c.rdy = 1'b1;
            opnd_c.val = bc_val;
        end
    end

endmodule

// File: rtl/arith_issue_queue.sv
// In-order-select reservation station feeding the arithmetic pipeline.
// Entries are kept compacted and age-ordered (slot 0 oldest). Each edge the
// oldest entry with all operands present is issued into the output
// registers and removed; younger entries shift down and a dispatched entry
// is appended at the resulting tail. Broadcasts wake waiting operands,
// including those of the entry being dispatched.
// Ports:
//   clk, rst_n, flush                 clock, async reset, sync clear
//   disp_*                            dispatch request and instruction fields
//   disp_ready                        queue has a free entry
//   cdb_*, cdb_flag_*                 result and flags broadcast buses
//   opcode..flags_val, instr_valid    registered issue port
//   count                             occupied entries
module arith_issue_queue
    import arith_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [OPC_W-1:0]            disp_opcode,
    input  logic [TAG_W-1:0]            disp_ROB_entry,
    input  logic [TAG_W-1:0]            disp_dest_reg,
    input  logic [TAG_W-1:0]            disp_flag_reg,
    input  logic [TAG_W-1:0]            disp_a_tag,
    input  logic [TAG_W-1:0]            disp_b_tag,
    input  logic [TAG_W-1:0]            disp_f_tag,
    input  logic                        disp_a_rdy,
    input  logic                        disp_b_rdy,
    input  logic                        disp_f_rdy,
    input  logic [DATA_W-1:0]           disp_a_val,
    input  logic [DATA_W-1:0]           disp_b_val,
    input  logic [DATA_W-1:0]           disp_f_val,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_reg,
    input  logic [DATA_W-1:0]           cdb_val,
    input  logic                        cdb_flag_valid,
    input  logic [TAG_W-1:0]            cdb_flag_reg,
    input  logic [DATA_W-1:0]           cdb_flags,
    output logic [OPC_W-1:0]            opcode,
    output logic [TAG_W-1:0]            ROB_entry,
    output logic [TAG_W-1:0]            dest_reg,
    output logic [TAG_W-1:0]            flag_reg,
    output logic [DATA_W-1:0]           op_a_val,
    output logic [DATA_W-1:0]           op_b_val,
    output logic [DATA_W-1:0]           flags_val,
    output logic                        instr_valid,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    rs_entry_t entries_q [DEPTH];
    rs_entry_t entries_d [DEPTH];
    rs_entry_t woken_c   [DEPTH+1];   // extra top slot is always empty, feeds the shift
    operand_t  a_w [DEPTH];
    operand_t  b_w [DEPTH];
    operand_t  f_w [DEPTH];

    operand_t  disp_a_in, disp_b_in, disp_f_in;
    operand_t  disp_a_w, disp_b_w, disp_f_w;
    rs_entry_t disp_e_c;

    logic             disp_fire_c;
    logic             sel_found_c;
    int               sel_idx_c;
    rs_entry_t        sel_e_c;
    logic [CNT_W-1:0] tail_c;

    assign disp_ready  = (count < CNT_W'(DEPTH));
    assign disp_fire_c = disp_valid && disp_ready;

    assign disp_a_in = {disp_a_tag, disp_a_rdy, disp_a_val};
    assign disp_b_in = {disp_b_tag, disp_b_rdy, disp_b_val};
    assign disp_f_in = {disp_f_tag, disp_f_rdy, disp_f_val};

    // Wakeup for stored entries: A/B listen to the result bus, F to the flags bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        arith_rs_entry_wakeup u_wake_a (
            .entry_valid (entries_q[i].valid), .opnd (entries_q[i].a),
            .bc_valid (cdb_valid), .bc_reg (cdb_reg), .bc_val (cdb_val),
            .opnd_c (a_w[i])
        );
        arith_rs_entry_wakeup u_wake_b (
            .entry_valid (entries_q[i].valid), .opnd (entries_q[i].b),
            .bc_valid (cdb_valid), .bc_reg (cdb_reg), .bc_val (cdb_val),
            .opnd_c (b_w[i])
        );
        arith_rs_entry_wakeup u_wake_f (
            .entry_valid (entries_q[i].valid), .opnd (entries_q[i].f),
            .bc_valid (cdb_flag_valid), .bc_reg (cdb_flag_reg), .bc_val (cdb_flags),
            .opnd_c (f_w[i])
        );
    end

    // Wakeup for the entry being dispatched this cycle.
    arith_rs_entry_wakeup u_wake_disp_a (
        .entry_valid (disp_valid), .opnd (disp_a_in),
        .bc_valid (cdb_valid), .bc_reg (cdb_reg), .bc_val (cdb_val),
        .opnd_c (disp_a_w)
    );
    arith_rs_entry_wakeup u_wake_disp_b (
        .entry_valid (disp_valid), .opnd (disp_b_in),
        .bc_valid (cdb_valid), .bc_reg (cdb_reg), .bc_val (cdb_val),
        .opnd_c (disp_b_w)
    );
    arith_rs_entry_wakeup u_wake_disp_f (
        .entry_valid (disp_valid), .opnd (disp_f_in),
        .bc_valid (cdb_flag_valid), .bc_reg (cdb_flag_reg), .bc_val (cdb_flags),
        .opnd_c (disp_f_w)
    );

    // Select uses the stored (pre-wakeup) ready bits, so a wakeup at edge N
    // can issue no earlier than edge N+1.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = 0;
        sel_e_c     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found_c && entry_issuable(entries_q[i])) begin
                sel_found_c = 1'b1;
                sel_idx_c   = i;
                sel_e_c     = entries_q[i];
            end
        end
    end

    // Next entry array: apply wakeup, close the gap left by the issued
    // entry, then append the dispatched entry at the new tail.
    always_comb begin
        disp_e_c          = '0;
        disp_e_c.valid    = 1'b1;
        disp_e_c.opcode   = disp_opcode;
        disp_e_c.rob      = disp_ROB_entry;
        disp_e_c.dest     = disp_dest_reg;
        disp_e_c.flag_reg = disp_flag_reg;
        disp_e_c.a        = disp_a_w;
        disp_e_c.b        = disp_b_w;
        disp_e_c.f        = disp_f_w;

        woken_c[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken_c[i]   = entries_q[i];
            woken_c[i].a = a_w[i];
            woken_c[i].b = b_w[i];
            woken_c[i].f = f_w[i];
        end

        tail_c = count - CNT_W'(sel_found_c);
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_found_c && (i >= sel_idx_c)) begin
                entries_d[i] = woken_c[i+1];
            end else begin
                entries_d[i] = woken_c[i];
            end
            if (disp_fire_c && (CNT_W'(i) == tail_c)) begin
                entries_d[i] = disp_e_c;
            end
        end
    end

    // State and issue registers; flush clears everything except via reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count       <= '0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            ROB_entry   <= '0;
            dest_reg    <= '0;
            flag_reg    <= '0;
            op_a_val    <= '0;
            op_b_val    <= '0;
            flags_val   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count       <= '0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            ROB_entry   <= '0;
            dest_reg    <= '0;
            flag_reg    <= '0;
            op_a_val    <= '0;
            op_b_val    <= '0;
            flags_val   <= '0;
        end else begin
            entries_q   <= entries_d;
            count       <= count + CNT_W'(disp_fire_c) - CNT_W'(sel_found_c);
            instr_valid <= sel_found_c;
            if (sel_found_c) begin
                opcode    <= sel_e_c.opcode;
                ROB_entry <= sel_e_c.rob;
                dest_reg  <= sel_e_c.dest;
                flag_reg  <= sel_e_c.flag_reg;
                op_a_val  <= sel_e_c.a.val;
                op_b_val  <= sel_e_c.b.val;
                flags_val <= sel_e_c.f.val;
            end
        end
    end

endmodule

// File: tb/tb_arith_issue_queue.sv
// Self-checking bench for arith_issue_queue: directed vector table,
// hand-written multi-cycle sequences, and random traffic against a
// queue-based reference model.
module tb_arith_issue_queue;

    localparam int DEPTH = 4;

    logic       clk, rst_n, flush;
    logic       disp_valid, disp_ready;
    logic [3:0] disp_opcode;
    logic [4:0] disp_ROB_entry, disp_dest_reg, disp_flag_reg;
    logic [4:0] disp_a_tag, disp_b_tag, disp_f_tag;
    logic       disp_a_rdy, disp_b_rdy, disp_f_rdy;
    logic [7:0] disp_a_val, disp_b_val, disp_f_val;
    logic       cdb_valid;
    logic [4:0] cdb_reg;
    logic [7:0] cdb_val;
    logic       cdb_flag_valid;
    logic [4:0] cdb_flag_reg;
    logic [7:0] cdb_flags;
    logic [3:0] opcode;
    logic [4:0] ROB_entry, dest_reg, flag_reg;
    logic [7:0] op_a_val, op_b_val, flags_val;
    logic       instr_valid;
    logic [2:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    arith_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .disp_valid (disp_valid), .disp_ready (disp_ready),
        .disp_opcode (disp_opcode), .disp_ROB_entry (disp_ROB_entry),
        .disp_dest_reg (disp_dest_reg), .disp_flag_reg (disp_flag_reg),
        .disp_a_tag (disp_a_tag), .disp_b_tag (disp_b_tag), .disp_f_tag (disp_f_tag),
        .disp_a_rdy (disp_a_rdy), .disp_b_rdy (disp_b_rdy), .disp_f_rdy (disp_f_rdy),
        .disp_a_val (disp_a_val), .disp_b_val (disp_b_val), .disp_f_val (disp_f_val),
        .cdb_valid (cdb_valid), .cdb_reg (cdb_reg), .cdb_val (cdb_val),
        .cdb_flag_valid (cdb_flag_valid), .cdb_flag_reg (cdb_flag_reg), .cdb_flags (cdb_flags),
        .opcode (opcode), .ROB_entry (ROB_entry), .dest_reg (dest_reg), .flag_reg (flag_reg),
        .op_a_val (op_a_val), .op_b_val (op_b_val), .flags_val (flags_val),
        .instr_valid (instr_valid), .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_ROB_entry = '0;
        disp_dest_reg = '0; disp_flag_reg = '0;
        disp_a_tag = '0; disp_b_tag = '0; disp_f_tag = '0;
        disp_a_rdy = 1'b0; disp_b_rdy = 1'b0; disp_f_rdy = 1'b0;
        disp_a_val = '0; disp_b_val = '0; disp_f_val = '0;
        cdb_valid = 1'b0; cdb_reg = '0; cdb_val = '0;
        cdb_flag_valid = 1'b0; cdb_flag_reg = '0; cdb_flags = '0;
    endtask

    // Dispatch with dest = rob+1, flag reg 0xF, flags present as 0xFF.
    task automatic drive_disp(input int opc, input int rob, input int at, input int ar,
                              input int av, input int bt, input int br, input int bv);
        disp_valid = 1'b1; disp_opcode = 4'(opc); disp_ROB_entry = 5'(rob);
        disp_dest_reg = 5'(rob + 1); disp_flag_reg = 5'hF;
        disp_a_tag = 5'(at); disp_a_rdy = 1'(ar); disp_a_val = 8'(av);
        disp_b_tag = 5'(bt); disp_b_rdy = 1'(br); disp_b_val = 8'(bv);
        disp_f_tag = 5'd0; disp_f_rdy = 1'b1; disp_f_val = 8'hFF;
    endtask

    task automatic drive_cdb(input int cv, input int creg, input int cval);
        cdb_valid = 1'(cv); cdb_reg = 5'(creg); cdb_val = 8'(cval);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int dv, opc, rob, at, ar, av, bt, br, bv, cv, creg, cval;
        int e_iv, e_opc, e_rob, e_a, e_b, e_cnt;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // ---------------- reference model ----------------
    typedef struct packed { logic [4:0] tag; logic rdy; logic [7:0] val; } m_op_t;
    typedef struct packed {
        logic [3:0] opc; logic [4:0] rob; logic [4:0] dest; logic [4:0] freg;
        m_op_t [2:0] op;   // 0 = A, 1 = B, 2 = flags
    } m_entry_t;

    m_entry_t   mq[$];
    logic       m_iv;
    logic [3:0] m_opc;
    logic [4:0] m_rob, m_dest, m_freg;
    logic [7:0] m_a, m_b, m_f;

    function automatic m_entry_t m_wake(input m_entry_t e);
        m_entry_t r = e;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                if (cdb_valid && !r.op[k].rdy && r.op[k].tag == cdb_reg) begin
                    r.op[k].rdy = 1'b1; r.op[k].val = cdb_val;
                end
            end else if (cdb_flag_valid && !r.op[k].rdy && r.op[k].tag == cdb_flag_reg) begin
                r.op[k].rdy = 1'b1; r.op[k].val = cdb_flags;
            end
        end
        return r;
    endfunction

    task automatic m_clear_outputs();
        m_iv = 1'b0; m_opc = '0; m_rob = '0; m_dest = '0; m_freg = '0;
        m_a = '0; m_b = '0; m_f = '0;
    endtask

    // Effect of one rising edge given the inputs currently driven.
    task automatic model_step();
        m_entry_t ne;
        bit accept;
        if (flush) begin
            mq.delete();
            m_clear_outputs();
            return;
        end
        accept = disp_valid && (mq.size() < DEPTH);
        m_iv = 1'b0;
        for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].op[0].rdy && mq[j].op[1].rdy && mq[j].op[2].rdy) begin
                m_iv = 1'b1; m_opc = mq[j].opc; m_rob = mq[j].rob; m_dest = mq[j].dest;
                m_freg = mq[j].freg; m_a = mq[j].op[0].val; m_b = mq[j].op[1].val;
                m_f = mq[j].op[2].val;
                mq.delete(j);
                break;
            end
        end
        for (int j = 0; j < mq.size(); j++) mq[j] = m_wake(mq[j]);
        if (accept) begin
            ne.opc = disp_opcode; ne.rob = disp_ROB_entry; ne.dest = disp_dest_reg;
            ne.freg = disp_flag_reg;
            ne.op[0].tag = disp_a_tag; ne.op[0].rdy = disp_a_rdy; ne.op[0].val = disp_a_val;
            ne.op[1].tag = disp_b_tag; ne.op[1].rdy = disp_b_rdy; ne.op[1].val = disp_b_val;
            ne.op[2].tag = disp_f_tag; ne.op[2].rdy = disp_f_rdy; ne.op[2].val = disp_f_val;
            mq.push_back(m_wake(ne));
        end
    endtask

    initial begin
        bit exp_ready;

        // dv opc rob  at ar  av   bt br  bv   cv creg cval | iv opc rob  a     b    cnt
        tbl[0]  = '{1, 0, 1,  0, 1, 'h01, 0, 1, 'h02, 0, 0, 0,      1'b0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      1, 0, 1, 'h01, 'h02, 0};
        tbl[2]  = '{1, 3, 2,  5, 0, 0,    0, 1, 'h10, 0, 0, 0,      0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      0, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    1, 5, 'h3C,   0, 0, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      1, 3, 2, 'h3C, 'h10, 0};
        tbl[6]  = '{1, 4, 3,  0, 1, 'h11, 9, 0, 0,    1, 9, 'hA5,   0, 0, 0, 0, 0, 1};
        tbl[7]  = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      1, 4, 3, 'h11, 'hA5, 0};
        tbl[8]  = '{1, 5, 4,  0, 0, 0,    0, 1, 'h22, 1, 0, 'h77,   0, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 6, 5,  0, 1, 'h01, 0, 1, 'h02, 0, 0, 0,      1, 5, 4, 'h77, 'h22, 1};
        tbl[10] = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      1, 6, 5, 'h01, 'h02, 0};
        tbl[11] = '{1, 7, 6,  6, 0, 0,    0, 1, 'h33, 1, 7, 'h99,   0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      0, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    1, 6, 'h66,   0, 0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 0,  0, 0, 0,    0, 0, 0,    0, 0, 0,      1, 7, 6, 'h66, 'h33, 0};

        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("reset_iv", 32'(instr_valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(disp_ready), 32'd1);
        chk("reset_rob", 32'(ROB_entry), 32'd0);
        #4 rst_n = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            if (tbl[i].dv != 0)
                drive_disp(tbl[i].opc, tbl[i].rob, tbl[i].at, tbl[i].ar, tbl[i].av,
                           tbl[i].bt, tbl[i].br, tbl[i].bv);
            drive_cdb(tbl[i].cv, tbl[i].creg, tbl[i].cval);
            step();
            chk($sformatf("tbl%0d_iv", i), 32'(instr_valid), 32'(tbl[i].e_iv));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_iv != 0) begin
                chk($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].e_opc));
                chk($sformatf("tbl%0d_rob", i), 32'(ROB_entry), 32'(tbl[i].e_rob));
                chk($sformatf("tbl%0d_dest", i), 32'(dest_reg), 32'(tbl[i].e_rob + 1));
                chk($sformatf("tbl%0d_flagreg", i), 32'(flag_reg), 32'h0F);
                chk($sformatf("tbl%0d_a", i), 32'(op_a_val), 32'(tbl[i].e_a));
                chk($sformatf("tbl%0d_b", i), 32'(op_b_val), 32'(tbl[i].e_b));
                chk($sformatf("tbl%0d_f", i), 32'(flags_val), 32'hFF);
            end
        end

        // ---- fill to full, broadcast, in-order drain ----
        idle_inputs();
        for (int r = 1; r <= 4; r++) begin
            drive_disp(r + 8, r, 7, 0, 0, 0, 1, r * 16);
            step();
        end
        idle_inputs();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(disp_ready), 32'd0);
        drive_disp(1, 9, 0, 1, 1, 0, 1, 1);    // must be ignored while full
        drive_cdb(1, 7, 'h70);
        step();
        chk("full_bcast_iv", 32'(instr_valid), 32'd0);
        chk("full_bcast_count", 32'(count), 32'd4);
        drive_cdb(0, 0, 0);                     // dispatch still requested during first issue
        for (int r = 1; r <= 4; r++) begin
            step();
            disp_valid = 1'b0;
            chk($sformatf("drain%0d_iv", r), 32'(instr_valid), 32'd1);
            chk($sformatf("drain%0d_rob", r), 32'(ROB_entry), 32'(r));
            chk($sformatf("drain%0d_a", r), 32'(op_a_val), 32'h70);
            chk($sformatf("drain%0d_b", r), 32'(op_b_val), 32'(r * 16));
            chk($sformatf("drain%0d_count", r), 32'(count), 32'(4 - r));
        end
        step();
        chk("drain_done_iv", 32'(instr_valid), 32'd0);
        chk("drain_done_count", 32'(count), 32'd0);

        // ---- async reset mid-cycle with two pending entries ----
        drive_disp(2, 21, 11, 0, 0, 0, 1, 5); step();
        drive_disp(2, 22, 11, 0, 0, 0, 1, 6); step();
        idle_inputs();
        chk("prerst_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_iv", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rob", 32'(ROB_entry), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_a", 32'(op_a_val), 32'd0);
        chk("rst_f", 32'(flags_val), 32'd0);
        #1 rst_n = 1'b1;
        drive_cdb(1, 11, 'h44);
        step();
        drive_cdb(0, 0, 0);
        chk("postrst_iv0", 32'(instr_valid), 32'd0);
        step();
        chk("postrst_iv1", 32'(instr_valid), 32'd0);
        chk("postrst_count", 32'(count), 32'd0);

        // ---- flush with simultaneous dispatch ----
        for (int r = 1; r <= 3; r++) begin
            drive_disp(3, r, 10, 0, 0, 0, 1, 1);
            step();
        end
        chk("preflush_count", 32'(count), 32'd3);
        drive_disp(3, 20, 0, 1, 1, 0, 1, 1);
        drive_cdb(1, 10, 'h55);
        flush = 1'b1;
        step();
        idle_inputs();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_iv", 32'(instr_valid), 32'd0);
        drive_cdb(1, 10, 'h56);
        for (int c = 0; c < 3; c++) begin
            step();
            drive_cdb(0, 0, 0);
            chk($sformatf("postflush%0d_iv", c), 32'(instr_valid), 32'd0);
        end
        chk("postflush_count", 32'(count), 32'd0);

        // ---- random traffic against the reference model ----
        idle_inputs();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        mq.delete();
        m_clear_outputs();
        for (int c = 0; c < 500; c++) begin
            flush          = ($urandom_range(0, 63) == 0);
            disp_valid     = ($urandom_range(0, 99) < 60);
            disp_opcode    = 4'($urandom);
            disp_ROB_entry = 5'($urandom);
            disp_dest_reg  = 5'($urandom);
            disp_flag_reg  = 5'($urandom);
            disp_a_tag = 5'($urandom_range(0, 7)); disp_a_rdy = 1'($urandom); disp_a_val = 8'($urandom);
            disp_b_tag = 5'($urandom_range(0, 7)); disp_b_rdy = 1'($urandom); disp_b_val = 8'($urandom);
            disp_f_tag = 5'($urandom_range(0, 7)); disp_f_rdy = 1'($urandom); disp_f_val = 8'($urandom);
            cdb_valid      = 1'($urandom);
            cdb_reg        = 5'($urandom_range(0, 7));
            cdb_val        = 8'($urandom);
            cdb_flag_valid = 1'($urandom);
            cdb_flag_reg   = 5'($urandom_range(0, 7));
            cdb_flags      = 8'($urandom);
            #1;
            exp_ready = (mq.size() < DEPTH);
            chk("rnd_ready", 32'(disp_ready), 32'(exp_ready));
            model_step();
            step();
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_iv", 32'(instr_valid), 32'(m_iv));
            chk("rnd_opcode", 32'(opcode), 32'(m_opc));
            chk("rnd_rob", 32'(ROB_entry), 32'(m_rob));
            chk("rnd_dest", 32'(dest_reg), 32'(m_dest));
            chk("rnd_flagreg", 32'(flag_reg), 32'(m_freg));
            chk("rnd_a", 32'(op_a_val), 32'(m_a));
            chk("rnd_b", 32'(op_b_val), 32'(m_b));
            chk("rnd_f", 32'(flags_val), 32'(m_f));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
